pa_idu_fls_dp: RTL and testbench
================================

# pa_idu_fls_dp

FP load/store dispatch stage in the IDU, directly downstream of the RV32F/D decoder. Buffers decoded FLW/FSW operations in a small in-order queue, checks each head entry against a 32-entry FPR busy scoreboard, and issues hazard-free operations to the LSU over a valid/ready handshake. Scoreboard bits are set when an FLW issues and cleared on LSU FP write-back.

## Interface
- DEPTH, 2, queue entries; a power of two, at least 2.
- forever_cpuclk  in  1  clock, rising edge.
- cpurst_b  in  1  reset; asynchronous, active-low.
- idu_fls_vld  in  1  decoded FP LSU op present (decoder op_vld with SEL_LSU).
- idu_fls_func  in  20  decoder func (FUNC_LW / FUNC_SW).
- idu_fls_store  in  1  1 = FSW, 0 = FLW.
- idu_fls_freg  in  5  FLW: destination FPR; FSW: data-source FPR.
- idu_fls_rs1  in  5  integer base register index.
- idu_fls_offset  in  12  sign-extended immediate offset, passed through unchanged.
- fls_idu_rdy  out  1  queue can accept this cycle.
- fls_lsu_vld  out  1  head entry issuing.
- lsu_fls_rdy  in  1  LSU accepts.
- fls_lsu_func  out  20  head func.
- fls_lsu_store  out  1  head store flag.
- fls_lsu_freg  out  5  head FPR index.
- fls_lsu_rs1  out  5  head base register.
- fls_lsu_offset  out  12  head offset.
- lsu_fls_wb_vld  in  1  FLW write-back complete.
- lsu_fls_wb_freg  in  5  FPR written back.
- rtu_fls_flush  in  1  pipeline flush.
- fls_idu_busy  out  1  queue non-empty or any scoreboard bit set.

## Operation
- Queue: circular, write pointer, read pointer, and count (width log2(DEPTH)+1). Strictly in order.
- Enqueue: when idu_fls_vld and fls_idu_rdy are both high, the entry is written at the write pointer. Pointers wrap modulo DEPTH.
- fls_idu_rdy = (count != DEPTH) & ~rtu_fls_flush. There is no enqueue pass-through when the queue is full, even if a dequeue happens in the same cycle.
- Hazard: hazard = head valid & sb[head freg] & ~bypass_clr, where bypass_clr applies only under the macro (see Configuration).
  - Applies to both ops: RAW for FSW, WAW for FLW.
- fls_lsu_vld = head valid & ~hazard & ~rtu_fls_flush. The fls_lsu_* payload always reflects the head entry. The payload is don't-care when the queue is empty.
- Dequeue: when fls_lsu_vld and lsu_fls_rdy are both high, the read pointer advances.
- Scoreboard: sb[31:0].
  - Set: an FLW dequeue sets sb[freg].
  - Clear: lsu_fls_wb_vld clears sb[wb_freg].
  - Same register set and cleared in one cycle: set wins.
  - Write-back to an idle bit: no effect.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Flush:
  - Queue: count and both pointers go to 0 at the next edge; issue and accept are both blocked in the flush cycle.
  - Scoreboard: unaffected, because already-issued FLWs still write back. A write-back in the flush cycle is still applied.
- Reset: count, pointers and sb are 0, and entry payload registers are 0.
  - Outputs after reset: fls_idu_rdy=1, fls_lsu_vld=0, fls_idu_busy=0, all fls_lsu_* payload=0.

## Timing
- Enqueue-to-issue latency is 1 cycle minimum: an entry accepted at edge N can drive fls_lsu_vld in cycle N+1.
- fls_lsu_vld depends combinationally on lsu_fls_wb_* only when the macro is defined. It never depends on lsu_fls_rdy.
- Once asserted, fls_lsu_vld holds with a stable payload until accepted, unless a flush occurs.
- Scoreboard updates take effect at the next edge.
- Throughput: 1 op/cycle sustained when hazard-free and the LSU is ready.

## Configuration
- PA_IDU_FLS_WB_BYPASS_EN defined:
  - bypass_clr = lsu_fls_wb_vld & (lsu_fls_wb_freg == head freg).
  - A head blocked on that register issues in the same cycle as its write-back.
- Not defined:
  - bypass_clr = 0.
  - Issue can happen at the earliest one cycle after the write-back cycle.

## Test plan
- Reset, then FLW f3 enqueued at cycle 1 with lsu_fls_rdy=1:
  - fls_lsu_vld=1 in cycle 2 with freg=3, store=0.
  - sb[3]=1 afterwards; fls_idu_busy stays 1 until write-back.
- FLW f5 issued, then FSW f5 enqueued; write-back of f5 at cycle W:
  - FSW issues at cycle W with the macro defined, W+1 without.
- lsu_fls_rdy held 0 with 3 FLW requests and DEPTH=2:
  - fls_idu_rdy drops after 2 accepts and the payload holds stable.
  - Releasing rdy drains the queue in order; the third op enters once count<2.
- Flush with 2 entries queued and sb[7]=1:
  - Next cycle count=0 and fls_lsu_vld=0, with sb[7] still 1.
  - A later write-back of f7 clears it and fls_idu_busy falls to 0.
- FLW f9 issues in the same cycle as write-back of f9 for an older FLW: sb[9] ends at 1 (set wins).
- cpurst_b asserted while the queue is non-empty and sb has bits set: all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pa_idu_fls_dp.sv
// FP load/store dispatch: in-order FLW/FSW queue with FPR busy scoreboard, issuing to the LSU.
// Optional same-cycle write-back bypass of the head hazard: define PA_IDU_FLS_WB_BYPASS_EN.
module pa_idu_fls_dp #(
  parameter int DEPTH = 2
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        idu_fls_vld,
  input  logic [19:0] idu_fls_func,
  input  logic        idu_fls_store,
  input  logic [4:0]  idu_fls_freg,
  input  logic [4:0]  idu_fls_rs1,
  input  logic [11:0] idu_fls_offset,
  output logic        fls_idu_rdy,
  output logic        fls_lsu_vld,
  input  logic        lsu_fls_rdy,
  output logic [19:0] fls_lsu_func,
  output logic        fls_lsu_store,
  output logic [4:0]  fls_lsu_freg,
  output logic [4:0]  fls_lsu_rs1,
  output logic [11:0] fls_lsu_offset,
  input  logic        lsu_fls_wb_vld,
  input  logic [4:0]  lsu_fls_wb_freg,
  input  logic        rtu_fls_flush,
  output logic        fls_idu_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [19:0]      func_q   [DEPTH];
  logic             store_q  [DEPTH];
  logic [4:0]       freg_q   [DEPTH];
  logic [4:0]       rs1_q    [DEPTH];
  logic [11:0]      offset_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      sb;
  logic [31:0]      sb_nxt;

  logic             head_vld;
  logic [4:0]       head_freg;
  logic             bypass_clr;
  logic             hazard;
  logic             enq;
  logic             deq;

  assign head_vld  = (count != '0);
  assign head_freg = freg_q[rd_ptr];

`ifdef PA_IDU_FLS_WB_BYPASS_EN
  assign bypass_clr = lsu_fls_wb_vld & (lsu_fls_wb_freg == head_freg);
`else
  assign bypass_clr = 1'b0;
`endif

  // One check covers RAW for FSW and WAW for FLW: both wait on the FPR's pending load.
  assign hazard      = head_vld & sb[head_freg] & ~bypass_clr;
  assign fls_idu_rdy = (count != CNT_W'(DEPTH)) & ~rtu_fls_flush;
  assign fls_lsu_vld = head_vld & ~hazard & ~rtu_fls_flush;
  assign enq         = idu_fls_vld & fls_idu_rdy;
  assign deq         = fls_lsu_vld & lsu_fls_rdy;
  assign fls_idu_busy = head_vld | (|sb);

  assign fls_lsu_func   = func_q[rd_ptr];
  assign fls_lsu_store  = store_q[rd_ptr];
  assign fls_lsu_freg   = head_freg;
  assign fls_lsu_rs1    = rs1_q[rd_ptr];
  assign fls_lsu_offset = offset_q[rd_ptr];

  // Set is applied after clear so an issuing FLW wins over a same-register write-back.
  always_comb begin
    sb_nxt = sb;
    if (lsu_fls_wb_vld) sb_nxt[lsu_fls_wb_freg] = 1'b0;
    if (deq && !store_q[rd_ptr]) sb_nxt[head_freg] = 1'b1;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sb <= '0;
    end else begin
      sb <= sb_nxt;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rtu_fls_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        func_q[i]   <= '0;
        store_q[i]  <= 1'b0;
        freg_q[i]   <= '0;
        rs1_q[i]    <= '0;
        offset_q[i] <= '0;
      end
    end else if (enq) begin
      func_q[wr_ptr]   <= idu_fls_func;
      store_q[wr_ptr]  <= idu_fls_store;
      freg_q[wr_ptr]   <= idu_fls_freg;
      rs1_q[wr_ptr]    <= idu_fls_rs1;
      offset_q[wr_ptr] <= idu_fls_offset;
    end
  end

endmodule

// File: tb/tb_pa_idu_fls_dp.sv
// Randomized scoreboard bench for pa_idu_fls_dp against a queue/bit-array reference model.
// Honours PA_IDU_FLS_WB_BYPASS_EN the same way as the design.
module tb_pa_idu_fls_dp;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [19:0] func;
    logic        store;
    logic [4:0]  freg;
    logic [4:0]  rs1;
    logic [11:0] offset;
  } op_t;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        idu_fls_vld;
  logic [19:0] idu_fls_func;
  logic        idu_fls_store;
  logic [4:0]  idu_fls_freg;
  logic [4:0]  idu_fls_rs1;
  logic [11:0] idu_fls_offset;
  logic        fls_idu_rdy;
  logic        fls_lsu_vld;
  logic        lsu_fls_rdy;
  logic [19:0] fls_lsu_func;
  logic        fls_lsu_store;
  logic [4:0]  fls_lsu_freg;
  logic [4:0]  fls_lsu_rs1;
  logic [11:0] fls_lsu_offset;
  logic        lsu_fls_wb_vld;
  logic [4:0]  lsu_fls_wb_freg;
  logic        rtu_fls_flush;
  logic        fls_idu_busy;

  int checks   = 0;
  int failures = 0;
  int issued   = 0;

  op_t       exp_q[$];
  bit [31:0] sb_m;

  pa_idu_fls_dp #(.DEPTH(DEPTH)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .idu_fls_vld    (idu_fls_vld),
    .idu_fls_func   (idu_fls_func),
    .idu_fls_store  (idu_fls_store),
    .idu_fls_freg   (idu_fls_freg),
    .idu_fls_rs1    (idu_fls_rs1),
    .idu_fls_offset (idu_fls_offset),
    .fls_idu_rdy    (fls_idu_rdy),
    .fls_lsu_vld    (fls_lsu_vld),
    .lsu_fls_rdy    (lsu_fls_rdy),
    .fls_lsu_func   (fls_lsu_func),
    .fls_lsu_store  (fls_lsu_store),
    .fls_lsu_freg   (fls_lsu_freg),
    .fls_lsu_rs1    (fls_lsu_rs1),
    .fls_lsu_offset (fls_lsu_offset),
    .lsu_fls_wb_vld (lsu_fls_wb_vld),
    .lsu_fls_wb_freg(lsu_fls_wb_freg),
    .rtu_fls_flush  (rtu_fls_flush),
    .fls_idu_busy   (fls_idu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},    32'(fls_idu_rdy),    32'd1);
    chk({tag, "_vld"},    32'(fls_lsu_vld),    32'd0);
    chk({tag, "_busy"},   32'(fls_idu_busy),   32'd0);
    chk({tag, "_func"},   32'(fls_lsu_func),   32'd0);
    chk({tag, "_store"},  32'(fls_lsu_store),  32'd0);
    chk({tag, "_freg"},   32'(fls_lsu_freg),   32'd0);
    chk({tag, "_rs1"},    32'(fls_lsu_rs1),    32'd0);
    chk({tag, "_offset"}, 32'(fls_lsu_offset), 32'd0);
  endtask

  // Small register range so hazards, set-vs-clear collisions and bypasses occur often.
  task automatic drive_rand(input int rdy_pct);
    idu_fls_vld     = ($urandom_range(0, 99) < 65);
    idu_fls_func    = 20'($urandom);
    idu_fls_store   = ($urandom_range(0, 99) < 40);
    idu_fls_freg    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    idu_fls_rs1     = 5'($urandom);
    idu_fls_offset  = 12'($urandom);
    lsu_fls_rdy     = ($urandom_range(0, 99) < rdy_pct);
    lsu_fls_wb_vld  = ($urandom_range(0, 99) < 35);
    lsu_fls_wb_freg = 5'($urandom_range(0, 3));
    rtu_fls_flush   = ($urandom_range(0, 99) < 5);
  endtask

  // Monitor: predicts every output mid-cycle from the model, then advances the model.
  bit  hv, byp, haz, rdy_e, vld_e, busy_e;
  op_t head, inop;
  bit [31:0] sb_n;

  always @(negedge clk) begin
    if (!cpurst_b) begin
      exp_q.delete();
      sb_m = '0;
    end else begin
      hv  = (exp_q.size() > 0);
      head = hv ? exp_q[0] : '0;
      byp = 1'b0;
`ifdef PA_IDU_FLS_WB_BYPASS_EN
      byp = hv && lsu_fls_wb_vld && (lsu_fls_wb_freg == head.freg);
`endif
      haz    = hv && sb_m[head.freg] && !byp;
      rdy_e  = (exp_q.size() != DEPTH) && !rtu_fls_flush;
      vld_e  = hv && !haz && !rtu_fls_flush;
      busy_e = hv || (sb_m != 0);

      chk("idu_rdy",  32'(fls_idu_rdy),  32'(rdy_e));
      chk("lsu_vld",  32'(fls_lsu_vld),  32'(vld_e));
      chk("idu_busy", 32'(fls_idu_busy), 32'(busy_e));
      if (hv) begin
        chk("head_func",   32'(fls_lsu_func),   32'(head.func));
        chk("head_store",  32'(fls_lsu_store),  32'(head.store));
        chk("head_freg",   32'(fls_lsu_freg),   32'(head.freg));
        chk("head_rs1",    32'(fls_lsu_rs1),    32'(head.rs1));
        chk("head_offset", 32'(fls_lsu_offset), 32'(head.offset));
      end

      sb_n = sb_m;
      if (lsu_fls_wb_vld) sb_n[lsu_fls_wb_freg] = 1'b0;
      if (vld_e && lsu_fls_rdy && !head.store) sb_n[head.freg] = 1'b1;
      sb_m = sb_n;

      if (rtu_fls_flush) begin
        exp_q.delete();
      end else begin
        if (vld_e && lsu_fls_rdy) begin
          void'(exp_q.pop_front());
          issued++;
        end
        if (idu_fls_vld && rdy_e) begin
          inop.func   = idu_fls_func;
          inop.store  = idu_fls_store;
          inop.freg   = idu_fls_freg;
          inop.rs1    = idu_fls_rs1;
          inop.offset = idu_fls_offset;
          exp_q.push_back(inop);
        end
      end
    end
  end

  task automatic idle_inputs();
    idu_fls_vld     = 1'b0;
    idu_fls_func    = '0;
    idu_fls_store   = 1'b0;
    idu_fls_freg    = '0;
    idu_fls_rs1     = '0;
    idu_fls_offset  = '0;
    lsu_fls_rdy     = 1'b0;
    lsu_fls_wb_vld  = 1'b0;
    lsu_fls_wb_freg = '0;
    rtu_fls_flush   = 1'b0;
  endtask

  initial begin
    cpurst_b = 1'b0;
    idle_inputs();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 cpurst_b = 1'b1;

    // Phases alternate LSU back-pressure so full-queue stalls and sustained drain both occur.
    for (int ph = 0; ph < 8; ph++) begin
      repeat (150) begin
        @(posedge clk);
        #1;
        drive_rand((ph % 2 == 0) ? 85 : 20);
      end
    end

    // Build up a non-empty queue with a pending FLW, then reset between edges.
    @(posedge clk); #1;
    idle_inputs();
    rtu_fls_flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    lsu_fls_wb_vld = 1'b1;
    lsu_fls_wb_freg = 5'd6;
    idu_fls_vld = 1'b1;
    idu_fls_freg = 5'd6;
    lsu_fls_rdy = 1'b1;
    idu_fls_offset = 12'hABC;
    @(posedge clk); #1;
    lsu_fls_wb_vld = 1'b0;
    idu_fls_freg = 5'd7;
    lsu_fls_rdy = 1'b0;
    @(posedge clk); #1;
    idu_fls_freg = 5'd8;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #2;
    chk("pre_reset_busy", 32'(fls_idu_busy), 32'd1);
    cpurst_b = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk); #2;
    cpurst_b = 1'b1;

    repeat (200) begin
      @(posedge clk);
      #1;
      drive_rand(70);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    if (issued < 50) begin
      failures++;
      $display("FAIL issue_count: got %0d issues, required at least 50", issued);
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
